// File: rtl/rob_multi_commit.sv
// rob_multi_commit: in-order reorder buffer with out-of-order writeback and up to COMMIT_W retirements per cycle.
// A separate occupancy counter tells full from empty when head and tail meet.
module rob_multi_commit #(
    parameter int DEPTH    = 16,
    parameter int XLEN     = 32,
    parameter int WB_PORTS = 2,
    parameter int COMMIT_W = 2,
    parameter int REG_W    = 5,
    parameter int LSB_W    = 3,
    localparam int ID_W    = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rdy,
    input  logic                         flush_in,
    input  logic                         alloc_valid,
    input  logic [1:0]                   alloc_class,
    input  logic [REG_W-1:0]             alloc_rd,
    input  logic [LSB_W-1:0]             alloc_lsb_id,
    input  logic                         alloc_done,
    input  logic [XLEN-1:0]              alloc_val,
    input  logic [XLEN-1:0]              alloc_addr,
    input  logic [XLEN-1:0]              alloc_inst_addr,
    input  logic [XLEN-1:0]              alloc_fallthru,
    input  logic                         alloc_pred,
    output logic [ID_W-1:0]              alloc_id,
    output logic                         full,
    output logic [ID_W:0]                count,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*ID_W-1:0]     wb_id,
    input  logic [WB_PORTS*XLEN-1:0]     wb_val,
    input  logic [WB_PORTS*XLEN-1:0]     wb_addr,
    input  logic [ID_W-1:0]              q1_id,
    input  logic [ID_W-1:0]              q2_id,
    output logic                         q1_ready,
    output logic                         q2_ready,
    output logic [XLEN-1:0]              q1_val,
    output logic [XLEN-1:0]              q2_val,
    output logic [COMMIT_W-1:0]          cm_rf_en,
    output logic [COMMIT_W*REG_W-1:0]    cm_rf_rd,
    output logic [COMMIT_W*XLEN-1:0]     cm_rf_val,
    output logic                         cm_store_en,
    output logic [LSB_W-1:0]             cm_store_lsb_id,
    output logic                         redirect,
    output logic [XLEN-1:0]              redirect_pc,
    output logic                         bp_en,
    output logic [XLEN-1:0]              bp_inst_addr,
    output logic                         bp_taken,
    output logic                         bp_correct,
    output logic [ID_W-1:0]              head_id,
    output logic [ID_W-1:0]              tail_id
);
    typedef enum logic [1:0] {C_REG, C_STORE, C_BR, C_JMP} cls_e;

    cls_e             cls_q  [DEPTH];
    logic [REG_W-1:0] rd_q   [DEPTH];
    logic [LSB_W-1:0] lsb_q  [DEPTH];
    logic [XLEN-1:0]  val_q  [DEPTH];
    logic [XLEN-1:0]  addr_q [DEPTH];
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [XLEN-1:0]  ft_q   [DEPTH];
    logic [DEPTH-1:0] pred_q;
    logic [DEPTH-1:0] ready_q;

    logic [ID_W-1:0] head_q, head_d, tail_q, tail_d, idx;
    logic [ID_W:0]   count_q, count_d, n;
    logic            alloc_en, redir_now, go, take;
    logic [WB_PORTS-1:0] wb_hit;

    logic [COMMIT_W-1:0]       rf_en_q, rf_en_d;
    logic [COMMIT_W*REG_W-1:0] rf_rd_q, rf_rd_d;
    logic [COMMIT_W*XLEN-1:0]  rf_val_q, rf_val_d;
    logic                      st_en_q, st_en_d, redir_q, bp_en_q, bp_en_d;
    logic                      bp_taken_q, bp_taken_d, bp_ok_q, bp_ok_d;
    logic [LSB_W-1:0]          st_id_q, st_id_d;
    logic [XLEN-1:0]           rpc_q, rpc_d, bp_pc_q, bp_pc_d;

    // A writeback counts only for ids inside the live window [head, head+count).
    for (genvar g = 0; g < WB_PORTS; g++) begin : g_wb
        logic [ID_W-1:0] off;
        assign off       = wb_id[g*ID_W +: ID_W] - head_q;
        assign wb_hit[g] = wb_valid[g] && !flush_in && ({1'b0, off} < count_q);
    end

    always_comb begin
        n         = '0;
        go        = 1'b1;
        take      = 1'b0;
        idx       = '0;
        redir_now = 1'b0;
        rf_en_d   = '0;
        rf_rd_d   = '0;
        rf_val_d  = '0;
        st_en_d   = 1'b0;
        st_id_d   = '0;
        rpc_d     = '0;
        bp_en_d   = 1'b0;
        bp_pc_d   = '0;
        bp_taken_d = 1'b0;
        bp_ok_d   = 1'b0;
        for (int k = 0; k < COMMIT_W; k++) begin
            idx  = head_q + ID_W'(k);
            take = go && !flush_in && ((ID_W+1)'(k) < count_q) && ready_q[idx];
            if (take) begin
                n = n + (ID_W+1)'(1);
                if (cls_q[idx] == C_REG || cls_q[idx] == C_JMP) begin
                    rf_en_d[k]                  = rd_q[idx] != '0;
                    rf_rd_d[k*REG_W +: REG_W]   = rd_q[idx];
                    rf_val_d[k*XLEN +: XLEN]    = val_q[idx];
                end
                if (cls_q[idx] == C_STORE) begin
                    st_en_d = 1'b1;
                    st_id_d = lsb_q[idx];
                end
                if (cls_q[idx] == C_BR) begin
                    bp_en_d    = 1'b1;
                    bp_pc_d    = pc_q[idx];
                    bp_taken_d = val_q[idx][0];
                    bp_ok_d    = pred_q[idx] == val_q[idx][0];
                    redir_now  = pred_q[idx] != val_q[idx][0];
                    rpc_d      = val_q[idx][0] ? addr_q[idx] : ft_q[idx];
                end
                if (cls_q[idx] == C_JMP) begin
                    redir_now = 1'b1;
                    rpc_d     = addr_q[idx];
                end
            end
            // Only a REG retirement lets the next lane proceed.
            go = take && cls_q[idx] == C_REG;
        end
    end

    assign full     = count_q == (ID_W+1)'(DEPTH);
    assign alloc_en = alloc_valid && !full && !redir_now && !flush_in;
    assign head_d   = head_q + n[ID_W-1:0];
    assign tail_d   = (flush_in || redir_now) ? head_d : tail_q + ID_W'(alloc_en);
    assign count_d  = (flush_in || redir_now) ? '0 : count_q + (ID_W+1)'(alloc_en) - n;

    always_comb begin
        q1_ready = ready_q[q1_id];
        q1_val   = val_q[q1_id];
        q2_ready = ready_q[q2_id];
        q2_val   = val_q[q2_id];
        for (int i = 0; i < WB_PORTS; i++) begin
            if (wb_hit[i] && wb_id[i*ID_W +: ID_W] == q1_id) begin
                q1_ready = 1'b1;
                q1_val   = (cls_q[q1_id] != C_JMP) ? wb_val[i*XLEN +: XLEN] : q1_val;
            end
            if (wb_hit[i] && wb_id[i*ID_W +: ID_W] == q2_id) begin
                q2_ready = 1'b1;
                q2_val   = (cls_q[q2_id] != C_JMP) ? wb_val[i*XLEN +: XLEN] : q2_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ready_q    <= '0;
            rf_en_q    <= '0;
            rf_rd_q    <= '0;
            rf_val_q   <= '0;
            st_en_q    <= 1'b0;
            st_id_q    <= '0;
            redir_q    <= 1'b0;
            rpc_q      <= '0;
            bp_en_q    <= 1'b0;
            bp_pc_q    <= '0;
            bp_taken_q <= 1'b0;
            bp_ok_q    <= 1'b0;
        end else if (rdy) begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_en_q    <= rf_en_d;
            rf_rd_q    <= rf_rd_d;
            rf_val_q   <= rf_val_d;
            st_en_q    <= st_en_d;
            st_id_q    <= st_id_d;
            redir_q    <= redir_now;
            rpc_q      <= rpc_d;
            bp_en_q    <= bp_en_d;
            bp_pc_q    <= bp_pc_d;
            bp_taken_q <= bp_taken_d;
            bp_ok_q    <= bp_ok_d;
            if (alloc_en) ready_q[tail_q] <= alloc_done;
            for (int i = 0; i < WB_PORTS; i++)
                if (wb_hit[i]) ready_q[wb_id[i*ID_W +: ID_W]] <= 1'b1;
        end
    end

    // Payload storage needs no reset; later ports overwrite earlier ones on the same id.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (alloc_en) begin
                cls_q[tail_q]  <= cls_e'(alloc_class);
                rd_q[tail_q]   <= alloc_rd;
                lsb_q[tail_q]  <= alloc_lsb_id;
                val_q[tail_q]  <= alloc_val;
                addr_q[tail_q] <= (cls_e'(alloc_class) == C_BR) ? alloc_addr : '0;
                pc_q[tail_q]   <= alloc_inst_addr;
                ft_q[tail_q]   <= alloc_fallthru;
                pred_q[tail_q] <= alloc_pred;
            end
            for (int i = 0; i < WB_PORTS; i++) begin
                if (wb_hit[i] && cls_q[wb_id[i*ID_W +: ID_W]] != C_JMP)
                    val_q[wb_id[i*ID_W +: ID_W]] <= wb_val[i*XLEN +: XLEN];
                if (wb_hit[i] && (cls_q[wb_id[i*ID_W +: ID_W]] == C_JMP || cls_q[wb_id[i*ID_W +: ID_W]] == C_STORE))
                    addr_q[wb_id[i*ID_W +: ID_W]] <= wb_addr[i*XLEN +: XLEN];
            end
        end
    end

    assign alloc_id        = tail_q;
    assign count           = count_q;
    assign head_id         = head_q;
    assign tail_id         = tail_q;
    assign cm_rf_en        = rf_en_q;
    assign cm_rf_rd        = rf_rd_q;
    assign cm_rf_val       = rf_val_q;
    assign cm_store_en     = st_en_q;
    assign cm_store_lsb_id = st_id_q;
    assign redirect        = redir_q;
    assign redirect_pc     = rpc_q;
    assign bp_en           = bp_en_q;
    assign bp_inst_addr    = bp_pc_q;
    assign bp_taken        = bp_taken_q;
    assign bp_correct      = bp_ok_q;
endmodule

// File: tb/tb_rob_multi_commit.sv
// tb_rob_multi_commit: directed self-checking bench for rob_multi_commit with hand-computed expectations.
module tb_rob_multi_commit;
    localparam int DEPTH = 16, XLEN = 32, WB_PORTS = 2, COMMIT_W = 2, REG_W = 5, LSB_W = 3, ID_W = 4;
    localparam logic [1:0] REG = 2'd0, STORE = 2'd1, BR = 2'd2, JMP = 2'd3;

    logic clk = 1'b0;
    logic rst_n, rdy, flush_in, alloc_valid, alloc_done, alloc_pred;
    logic [1:0] alloc_class;
    logic [REG_W-1:0] alloc_rd;
    logic [LSB_W-1:0] alloc_lsb_id;
    logic [XLEN-1:0] alloc_val, alloc_addr, alloc_inst_addr, alloc_fallthru;
    logic [ID_W-1:0] alloc_id, q1_id, q2_id, head_id, tail_id;
    logic full, q1_ready, q2_ready, cm_store_en, redirect, bp_en, bp_taken, bp_correct;
    logic [ID_W:0] count;
    logic [WB_PORTS-1:0] wb_valid;
    logic [WB_PORTS*ID_W-1:0] wb_id;
    logic [WB_PORTS*XLEN-1:0] wb_val, wb_addr;
    logic [XLEN-1:0] q1_val, q2_val, redirect_pc, bp_inst_addr;
    logic [COMMIT_W-1:0] cm_rf_en;
    logic [COMMIT_W*REG_W-1:0] cm_rf_rd;
    logic [COMMIT_W*XLEN-1:0] cm_rf_val;
    logic [LSB_W-1:0] cm_store_lsb_id;

    int checks = 0;
    int errors = 0;

    rob_multi_commit #(.DEPTH(DEPTH), .XLEN(XLEN), .WB_PORTS(WB_PORTS), .COMMIT_W(COMMIT_W),
                       .REG_W(REG_W), .LSB_W(LSB_W)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush_in(flush_in),
        .alloc_valid(alloc_valid), .alloc_class(alloc_class), .alloc_rd(alloc_rd),
        .alloc_lsb_id(alloc_lsb_id), .alloc_done(alloc_done), .alloc_val(alloc_val),
        .alloc_addr(alloc_addr), .alloc_inst_addr(alloc_inst_addr), .alloc_fallthru(alloc_fallthru),
        .alloc_pred(alloc_pred), .alloc_id(alloc_id), .full(full), .count(count),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val), .wb_addr(wb_addr),
        .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_val(q1_val), .q2_val(q2_val), .cm_rf_en(cm_rf_en), .cm_rf_rd(cm_rf_rd),
        .cm_rf_val(cm_rf_val), .cm_store_en(cm_store_en), .cm_store_lsb_id(cm_store_lsb_id),
        .redirect(redirect), .redirect_pc(redirect_pc), .bp_en(bp_en), .bp_inst_addr(bp_inst_addr),
        .bp_taken(bp_taken), .bp_correct(bp_correct), .head_id(head_id), .tail_id(tail_id)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic alloc(input logic [1:0] c, input logic [REG_W-1:0] rd, input logic [LSB_W-1:0] lsb,
                         input logic done, input logic [XLEN-1:0] val, input logic [XLEN-1:0] addr,
                         input logic [XLEN-1:0] pc, input logic pred);
        alloc_valid = 1'b1; alloc_class = c; alloc_rd = rd; alloc_lsb_id = lsb; alloc_done = done;
        alloc_val = val; alloc_addr = addr; alloc_inst_addr = pc; alloc_fallthru = pc + 32'd4;
        alloc_pred = pred;
    endtask

    task automatic wb(input int p, input logic [ID_W-1:0] id, input logic [XLEN-1:0] val, input logic [XLEN-1:0] addr);
        wb_valid[p] = 1'b1;
        wb_id[p*ID_W +: ID_W] = id;
        wb_val[p*XLEN +: XLEN] = val;
        wb_addr[p*XLEN +: XLEN] = addr;
    endtask

    task automatic idle;
        alloc_valid = 1'b0; wb_valid = '0; flush_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush_in = 1'b0; alloc_valid = 1'b0; alloc_class = REG;
        alloc_rd = '0; alloc_lsb_id = '0; alloc_done = 1'b0; alloc_val = '0; alloc_addr = '0;
        alloc_inst_addr = '0; alloc_fallthru = '0; alloc_pred = 1'b0; wb_valid = '0; wb_id = '0;
        wb_val = '0; wb_addr = '0; q1_id = '0; q2_id = '0;
        tick; tick;
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_head", head_id, 0);
        chk("rst_tail", tail_id, 0);
        chk("rst_rf_en", cm_rf_en, 0);
        chk("rst_redirect", redirect, 0);
        chk("rst_bp_en", bp_en, 0);
        chk("rst_store_en", cm_store_en, 0);
        chk("rst_q1_ready", q1_ready, 0);
        rst_n = 1'b1;

        // back-to-back completed REG allocations retire one per cycle
        alloc(REG, 5'd1, 3'd0, 1'b1, 32'd10, 32'd0, 32'd0, 1'b0);
        chk("t1_alloc_id", alloc_id, 0);
        tick;
        chk("t1_count1", count, 1);
        chk("t1_rf_en0", cm_rf_en, 0);
        alloc(REG, 5'd2, 3'd0, 1'b1, 32'd20, 32'd0, 32'd0, 1'b0);
        tick;
        chk("t1_rf_en_a", cm_rf_en, 2'b01);
        chk("t1_rd_a", cm_rf_rd[REG_W-1:0], 1);
        chk("t1_val_a", cm_rf_val[XLEN-1:0], 10);
        alloc(REG, 5'd3, 3'd0, 1'b1, 32'd30, 32'd0, 32'd0, 1'b0);
        tick;
        chk("t1_val_b", cm_rf_val[XLEN-1:0], 20);
        alloc(REG, 5'd4, 3'd0, 1'b1, 32'd40, 32'd0, 32'd0, 1'b0);
        tick;
        chk("t1_val_c", cm_rf_val[XLEN-1:0], 30);
        idle;
        tick;
        chk("t1_rf_en_d", cm_rf_en, 2'b01);
        chk("t1_rd_d", cm_rf_rd[REG_W-1:0], 4);
        chk("t1_val_d", cm_rf_val[XLEN-1:0], 40);
        chk("t1_count0", count, 0);
        chk("t1_head", head_id, 4);
        chk("t1_tail", tail_id, 4);
        tick;
        chk("t1_rf_en_pulse", cm_rf_en, 0);

        // head blocked until writeback, then two lanes retire together
        alloc(REG, 5'd5, 3'd0, 1'b0, 32'd50, 32'd0, 32'd0, 1'b0);
        tick;
        alloc(REG, 5'd6, 3'd0, 1'b1, 32'd60, 32'd0, 32'd0, 1'b0);
        tick;
        chk("t2_count2", count, 2);
        chk("t2_blocked", cm_rf_en, 0);
        alloc(REG, 5'd7, 3'd0, 1'b1, 32'd70, 32'd0, 32'd0, 1'b0);
        wb(0, 4'd4, 32'd55, 32'd0);
        q1_id = 4'd4;
        #1;
        chk("t2_bypass_ready", q1_ready, 1);
        chk("t2_bypass_val", q1_val, 55);
        tick;
        chk("t2_count3", count, 3);
        chk("t2_no_retire", cm_rf_en, 0);
        idle;
        tick;
        chk("t2_dual_en", cm_rf_en, 2'b11);
        chk("t2_dual_rd", cm_rf_rd, {5'd6, 5'd5});
        chk("t2_dual_val", cm_rf_val, {32'd60, 32'd55});
        chk("t2_count1", count, 1);
        chk("t2_head", head_id, 6);
        tick;
        chk("t2_last_en", cm_rf_en, 2'b01);
        chk("t2_last_rd", cm_rf_rd[REG_W-1:0], 7);
        chk("t2_count0", count, 0);
        tick;
        chk("t2_idle_en", cm_rf_en, 0);

        // fill all entries, overflow alloc ignored, then drain one
        for (int i = 0; i < DEPTH; i++) begin
            alloc(REG, REG_W'(i + 1), 3'd0, 1'b0, XLEN'(i), 32'd0, 32'd0, 1'b0);
            tick;
        end
        chk("t3_full", full, 1);
        chk("t3_count16", count, 16);
        chk("t3_head", head_id, 7);
        chk("t3_tail", tail_id, 7);
        alloc(REG, 5'd9, 3'd0, 1'b1, 32'd9, 32'd0, 32'd0, 1'b0);
        tick;
        chk("t3_ovf_count", count, 16);
        chk("t3_ovf_tail", tail_id, 7);
        idle;
        wb(0, 4'd7, 32'h77, 32'd0);
        tick;
        chk("t3_wb_count", count, 16);
        idle;
        tick;
        chk("t3_drain_en", cm_rf_en, 2'b01);
        chk("t3_drain_rd", cm_rf_rd[REG_W-1:0], 1);
        chk("t3_drain_val", cm_rf_val[XLEN-1:0], 32'h77);
        chk("t3_drain_count", count, 15);
        chk("t3_drain_full", full, 0);
        chk("t3_drain_head", head_id, 8);
        wb(0, 4'd8, 32'h88, 32'd0);
        tick;
        chk("t3_pre_flush_en", cm_rf_en, 0);

        // flush beats a ready head, an allocation and a writeback
        idle;
        flush_in = 1'b1;
        alloc(REG, 5'd9, 3'd0, 1'b1, 32'd9, 32'd0, 32'd0, 1'b0);
        wb(1, 4'd9, 32'h99, 32'd0);
        tick;
        chk("t4_flush_en", cm_rf_en, 0);
        chk("t4_flush_head", head_id, 8);
        chk("t4_flush_tail", tail_id, 8);
        chk("t4_flush_count", count, 0);
        idle;
        tick;
        chk("t4_after_en", cm_rf_en, 0);

        // mispredicted branch redirects and squashes the younger REG
        alloc(BR, 5'd0, 3'd0, 1'b0, 32'd0, 32'h100, 32'h40, 1'b0);
        tick;
        alloc(REG, 5'd3, 3'd0, 1'b1, 32'h33, 32'd0, 32'd0, 1'b0);
        tick;
        chk("t5_count2", count, 2);
        idle;
        wb(1, 4'd8, 32'd1, 32'd0);
        tick;
        chk("t5_bp_pre", bp_en, 0);
        idle;
        alloc(REG, 5'd4, 3'd0, 1'b1, 32'h44, 32'd0, 32'd0, 1'b0);
        tick;
        chk("t5_bp_en", bp_en, 1);
        chk("t5_bp_taken", bp_taken, 1);
        chk("t5_bp_correct", bp_correct, 0);
        chk("t5_bp_pc", bp_inst_addr, 32'h40);
        chk("t5_redirect", redirect, 1);
        chk("t5_redirect_pc", redirect_pc, 32'h100);
        chk("t5_rf_en", cm_rf_en, 0);
        chk("t5_count", count, 0);
        chk("t5_head", head_id, 9);
        chk("t5_tail", tail_id, 9);
        idle;
        tick;
        chk("t5_redirect_pulse", redirect, 0);
        chk("t5_bp_pulse", bp_en, 0);

        // two stores release on consecutive cycles
        alloc(STORE, 5'd0, 3'd5, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        tick;
        alloc(STORE, 5'd0, 3'd6, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0);
        tick;
        chk("t6_count2", count, 2);
        chk("t6_st_pre", cm_store_en, 0);
        idle;
        wb(0, 4'd9, 32'd1, 32'h200);
        tick;
        chk("t6_st_wb", cm_store_en, 0);
        idle;
        tick;
        chk("t6_st_a_en", cm_store_en, 1);
        chk("t6_st_a_id", cm_store_lsb_id, 5);
        chk("t6_st_a_count", count, 1);
        tick;
        chk("t6_st_b_en", cm_store_en, 1);
        chk("t6_st_b_id", cm_store_lsb_id, 6);
        chk("t6_st_b_count", count, 0);
        tick;
        chk("t6_st_pulse", cm_store_en, 0);

        // two ports on one id: higher port wins; non-live writeback ignored
        alloc(REG, 5'd7, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        tick;
        idle;
        wb(0, 4'd11, 32'd5, 32'd0);
        wb(1, 4'd11, 32'd7, 32'd0);
        q1_id = 4'd11;
        q2_id = 4'd11;
        #1;
        chk("t7_q1_val", q1_val, 7);
        chk("t7_q2_ready", q2_ready, 1);
        chk("t7_q2_val", q2_val, 7);
        tick;
        idle;
        wb(0, 4'd12, 32'hdead, 32'd0);
        tick;
        chk("t7_rf_en", cm_rf_en, 2'b01);
        chk("t7_rf_rd", cm_rf_rd[REG_W-1:0], 7);
        chk("t7_rf_val", cm_rf_val[XLEN-1:0], 7);
        idle;
        q1_id = 4'd12;
        #1;
        chk("t7_nonlive_ready", q1_ready, 0);
        chk("t7_nonlive_count", count, 0);

        // jalr: link value kept, target taken from writeback address
        alloc(JMP, 5'd1, 3'd0, 1'b0, 32'h48, 32'd0, 32'h44, 1'b0);
        tick;
        idle;
        wb(0, 4'd12, 32'hbad, 32'h300);
        #1;
        chk("t8_q_ready", q1_ready, 1);
        chk("t8_q_val", q1_val, 32'h48);
        tick;
        idle;
        tick;
        chk("t8_rf_en", cm_rf_en, 2'b01);
        chk("t8_rf_rd", cm_rf_rd[REG_W-1:0], 1);
        chk("t8_rf_val", cm_rf_val[XLEN-1:0], 32'h48);
        chk("t8_redirect", redirect, 1);
        chk("t8_redirect_pc", redirect_pc, 32'h300);
        chk("t8_bp_en", bp_en, 0);
        chk("t8_head", head_id, 13);
        chk("t8_tail", tail_id, 13);

        // rdy low freezes state and registered outputs
        rdy = 1'b0;
        alloc(REG, 5'd2, 3'd0, 1'b1, 32'd2, 32'd0, 32'd0, 1'b0);
        tick;
        chk("t9_frozen_redirect", redirect, 1);
        chk("t9_frozen_count", count, 0);
        chk("t9_frozen_tail", tail_id, 13);
        rdy = 1'b1;
        idle;
        tick;
        chk("t9_resume_redirect", redirect, 0);
        chk("t9_resume_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
